// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mdu_pkg
//  Purpose : Shared definitions for the multiply/divide unit and its
//            pipeline-side issue logic: op codes, issue FSM state encoding
//            and default MDU latencies.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mdu_pkg;

  // Op codes carried on the Op bus to the MDU
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  // Busy window of the MDU after it samples an op
  localparam int MDU_MUL_LAT = 5;
  localparam int MDU_DIV_LAT = 10;

  // Issue FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } mdu_state_e;

  // Ops that leave the MDU busy for the multiply latency
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  // Ops that leave the MDU busy for the divide latency (nonzero divisor)
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_issue_lat_cnt.sv
`default_nettype none
// ============================================================================
//  Module  : mdu_lat_cnt
//  Purpose : Shadow counter mirroring the MDU busy window. Loaded once when a
//            request is issued, then counts down to zero.
//  Ports   : clk      - clock
//            reset    - asynchronous active-low reset
//            load     - load load_val this edge (has priority)
//            load_val - value to load
//            dec      - decrement this edge (saturates at zero)
//            cnt      - current count
//            zero     - cnt == 0
//  Rev     : 1.0  initial release
// ============================================================================
module mdu_lat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mdu_issue.sv
`default_nettype none
// ============================================================================
//  Module  : mdu_issue
//  Purpose : E-stage initiator for the multiply/divide unit. Registers an MDU
//            request for one cycle, drives Op/A/B, shadows the MDU busy
//            window, stalls the pipeline on hazards and returns hi/lo data.
//            Build option MDU_ISSUE_CHECK_EN enables a sticky protocol check
//            of mdu_busy against the shadow counter (proto_err); otherwise
//            proto_err is tied low.
//  Ports   : clk, reset (async active-low)
//            e_valid, e_op, e_rd_hi, e_rd_lo, e_a, e_b, e_flush - E stage
//            req_kill  - cancel the registered request (flushed in M)
//            stall     - freeze F/D/E
//            rd_data   - hi/lo read data for mfhi/mflo
//            mdu_op, mdu_a, mdu_b - request to the MDU
//            mdu_busy, mdu_hi, mdu_lo - MDU status and results
//            proto_err - sticky busy-window mismatch
//  Rev     : 1.0  initial release
// ============================================================================
module mdu_issue
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MDU_MUL_LAT,
  parameter int DIV_LAT = MDU_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic        e_rd_hi,
  input  logic        e_rd_lo,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic        e_flush,
  input  logic        req_kill,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic [3:0]  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic        proto_err
);

  localparam int CNT_W = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1);

  mdu_state_e       r_state, w_next;
  logic [3:0]       r_req_op;
  logic [31:0]      r_req_a, r_req_b;
  logic [CNT_W-1:0] w_cnt, w_load_val;
  logic             w_cnt_zero, w_load, w_dec;
  logic             w_use, w_hazard, w_accept;

  assign w_use    = e_valid & ((e_op != MDU_NONE) | e_rd_hi | e_rd_lo);
  assign w_hazard = (r_state != IDLE) | mdu_busy;
  // stall deliberately ignores e_flush to keep it off the flush timing path
  assign stall    = w_use & w_hazard;
  assign w_accept = e_valid & (e_op != MDU_NONE) & ~w_hazard & ~e_flush;

  assign rd_data = e_rd_hi ? mdu_hi : (e_rd_lo ? mdu_lo : 32'd0);
  assign mdu_a   = r_req_a;
  assign mdu_b   = r_req_b;

  // Busy window the MDU will enter when it samples the registered request
  always_comb begin
    w_load_val = '0;
    if (!req_kill) begin
      if (is_mul_op(r_req_op)) begin
        w_load_val = CNT_W'(MUL_LAT);
      end else if (is_div_op(r_req_op) && (r_req_b != 32'd0)) begin
        w_load_val = CNT_W'(DIV_LAT);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    mdu_op = MDU_NONE;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = ISSUE;
      end
      ISSUE: begin
        mdu_op = req_kill ? MDU_NONE : r_req_op;
        w_load = 1'b1;
        w_next = (w_load_val != '0) ? WAIT : IDLE;
      end
      WAIT: begin
        w_dec = 1'b1;
        // exit on the 1->0 transition; zero is a defensive escape
        if ((w_cnt == CNT_W'(1)) || w_cnt_zero) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_req_op <= MDU_NONE;
      r_req_a  <= 32'd0;
      r_req_b  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == ISSUE) begin
        r_req_op <= MDU_NONE;
      end else if (w_accept) begin
        r_req_op <= e_op;
        r_req_a  <= e_a;
        r_req_b  <= e_b;
      end
    end
  end

  mdu_lat_cnt #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (w_dec),
    .cnt      (w_cnt),
    .zero     (w_cnt_zero)
  );

`ifdef MDU_ISSUE_CHECK_EN
  logic r_proto_err;

  // In ISSUE the MDU has not yet sampled the op, so busy is not comparable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_proto_err <= 1'b0;
    end else if ((r_state != ISSUE) && (mdu_busy != ~w_cnt_zero)) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mdu_issue
//  Purpose : Self-checking bench for mdu_issue with a behavioural MDU.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mdu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid, e_rd_hi, e_rd_lo, e_flush, req_kill;
  logic [3:0]  e_op;
  logic [31:0] e_a, e_b;
  logic        stall, proto_err;
  logic [31:0] rd_data, mdu_a, mdu_b;
  logic [3:0]  mdu_op;
  logic        mdu_busy;
  logic [31:0] mdu_hi, mdu_lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_issue dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_op      (e_op),
    .e_rd_hi   (e_rd_hi),
    .e_rd_lo   (e_rd_lo),
    .e_a       (e_a),
    .e_b       (e_b),
    .e_flush   (e_flush),
    .req_kill  (req_kill),
    .stall     (stall),
    .rd_data   (rd_data),
    .mdu_op    (mdu_op),
    .mdu_a     (mdu_a),
    .mdu_b     (mdu_b),
    .mdu_busy  (mdu_busy),
    .mdu_hi    (mdu_hi),
    .mdu_lo    (mdu_lo),
    .proto_err (proto_err)
  );

  // Behavioural MDU: samples Op each edge, busy 5 (mul) / 10 (div) cycles
  logic [3:0]  bcnt;
  logic        busy_force;
  logic [63:0] m_prod;
  assign mdu_busy = (bcnt != 4'd0) | busy_force;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt   <= 4'd0;
      mdu_hi <= 32'd0;
      mdu_lo <= 32'd0;
    end else begin
      if (bcnt != 4'd0) bcnt <= bcnt - 4'd1;
      case (mdu_op)
        4'd1: begin
          m_prod = {{32{mdu_a[31]}}, mdu_a} * {{32{mdu_b[31]}}, mdu_b};
          {mdu_hi, mdu_lo} <= m_prod;
          bcnt <= 4'd5;
        end
        4'd2: begin
          m_prod = {32'd0, mdu_a} * {32'd0, mdu_b};
          {mdu_hi, mdu_lo} <= m_prod;
          bcnt <= 4'd5;
        end
        4'd3: if (mdu_b != 32'd0) begin
          mdu_lo <= $signed(mdu_a) / $signed(mdu_b);
          mdu_hi <= $signed(mdu_a) % $signed(mdu_b);
          bcnt   <= 4'd10;
        end
        4'd4: if (mdu_b != 32'd0) begin
          mdu_lo <= mdu_a / mdu_b;
          mdu_hi <= mdu_a % mdu_b;
          bcnt   <= 4'd10;
        end
        4'd7: mdu_hi <= mdu_a;
        4'd8: mdu_lo <= mdu_a;
        default: ;
      endcase
    end
  end

  task automatic idle_in();
    e_valid = 1'b0; e_op = 4'd0; e_rd_hi = 1'b0; e_rd_lo = 1'b0;
    e_a = 32'd0; e_b = 32'd0; e_flush = 1'b0; req_kill = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    idle_in();
    e_valid = 1'b1; e_op = op; e_a = a; e_b = b;
  endtask

  task automatic drive_rd(input logic hi);
    idle_in();
    e_valid = 1'b1; e_rd_hi = hi; e_rd_lo = ~hi;
  endtask

  // Called at a negedge; counts stalled cycles, bounded, ends at a negedge
  task automatic count_stalls(output int n);
    n = 0;
    while (stall && n < 40) begin
      n++;
      step();
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1'b0;
    busy_force = 1'b0;
    e_valid = 1'b1; e_rd_lo = 1'b1;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (mdu_op !== 4'd0) begin bad++; $display("FAIL reset_op got=%0d exp=0", mdu_op); end
    total++; if (mdu_a !== 32'd0 || mdu_b !== 32'd0) begin bad++; $display("FAIL reset_ab got=%h/%h exp=0/0", mdu_a, mdu_b); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", proto_err); end
    step();
    reset = 1'b1;
    idle_in();
    step();
  endtask

  task automatic test_mult();
    int n;
    drive_op(4'd1, 32'hFFFF_FFFD, 32'd7);
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mult_accept_stall got=%b exp=0", stall); end
    step();
    drive_rd(1'b0);
    @(negedge clk);
    total++; if (mdu_op !== 4'd1) begin bad++; $display("FAIL mult_issue_op got=%0d exp=1", mdu_op); end
    total++; if (mdu_a !== 32'hFFFF_FFFD || mdu_b !== 32'd7) begin bad++; $display("FAIL mult_issue_ab got=%h/%h exp=fffffffd/7", mdu_a, mdu_b); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mult_issue_stall got=%b exp=1", stall); end
    count_stalls(n);
    total++; if (n != 6) begin bad++; $display("FAIL mult_mflo_stalls got=%0d exp=6", n); end
    total++; if (rd_data !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_mflo_data got=%h exp=ffffffeb", rd_data); end
    total++; if (mdu_a !== 32'hFFFF_FFFD) begin bad++; $display("FAIL mult_hold_a got=%h exp=fffffffd", mdu_a); end
    step();
    idle_in();
    step();
  endtask

  task automatic test_div_zero();
    int n;
    drive_op(4'd3, 32'd7, 32'd0);
    step();
    drive_rd(1'b1);
    @(negedge clk);
    total++; if (mdu_op !== 4'd3) begin bad++; $display("FAIL divz_issue_op got=%0d exp=3", mdu_op); end
    count_stalls(n);
    total++; if (n != 1) begin bad++; $display("FAIL divz_mfhi_stalls got=%0d exp=1", n); end
    total++; if (rd_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_mfhi_data got=%h exp=ffffffff", rd_data); end
    step();
    idle_in();
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    drive_op(4'd4, 32'd100, 32'd7);
    step();
    drive_op(4'd1, 32'd100, 32'd3);
    @(negedge clk);
    total++; if (mdu_op !== 4'd4) begin bad++; $display("FAIL b2b_divu_op got=%0d exp=4", mdu_op); end
    count_stalls(n);
    total++; if (n != 11) begin bad++; $display("FAIL b2b_mult_stalls got=%0d exp=11", n); end
    step();
    drive_rd(1'b0);
    @(negedge clk);
    total++; if (mdu_op !== 4'd1 || mdu_a !== 32'd100 || mdu_b !== 32'd3) begin bad++; $display("FAIL b2b_mult_issue got=%0d %h %h exp=1 64 3", mdu_op, mdu_a, mdu_b); end
    count_stalls(n);
    total++; if (n != 6) begin bad++; $display("FAIL b2b_mflo_stalls got=%0d exp=6", n); end
    total++; if (rd_data !== 32'd300) begin bad++; $display("FAIL b2b_lo got=%h exp=12c", rd_data); end
    e_rd_lo = 1'b0; e_rd_hi = 1'b1;
    #1;
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL b2b_hi got=%h exp=0", rd_data); end
    e_rd_hi = 1'b0;
    #1;
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rd_none got=%h exp=0", rd_data); end
    step();
    idle_in();
    step();
  endtask

  task automatic test_mthi_mfhi();
    int n;
    drive_op(4'd7, 32'hCAFE_BABE, 32'd0);
    step();
    drive_rd(1'b1);
    @(negedge clk);
    count_stalls(n);
    total++; if (n != 1) begin bad++; $display("FAIL mthi_mfhi_stalls got=%0d exp=1", n); end
    total++; if (rd_data !== 32'hCAFE_BABE) begin bad++; $display("FAIL mthi_mfhi_data got=%h exp=cafebabe", rd_data); end
    step();
    idle_in();
    step();
  endtask

  task automatic test_kill();
    int n;
    drive_op(4'd8, 32'h1234_5678, 32'd0);
    step();
    drive_rd(1'b0);
    req_kill = 1'b1;
    @(negedge clk);
    total++; if (mdu_op !== 4'd0) begin bad++; $display("FAIL kill_op got=%0d exp=0", mdu_op); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL kill_stall got=%b exp=1", stall); end
    count_stalls(n);
    total++; if (n != 1) begin bad++; $display("FAIL kill_stalls got=%0d exp=1", n); end
    total++; if (rd_data !== 32'd300) begin bad++; $display("FAIL kill_old_lo got=%h exp=12c", rd_data); end
    total++; if (mdu_a !== 32'h1234_5678) begin bad++; $display("FAIL kill_reg_a got=%h exp=12345678", mdu_a); end
    step();
    idle_in();
    step();
  endtask

  task automatic test_flush();
    drive_op(4'd1, 32'd5, 32'd5);
    e_flush = 1'b1;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
    step();
    drive_rd(1'b0);
    @(negedge clk);
    total++; if (stall !== 1'b0 || mdu_op !== 4'd0) begin bad++; $display("FAIL flush_no_issue got=stall %b op %0d exp=0 0", stall, mdu_op); end
    total++; if (mdu_a !== 32'h1234_5678) begin bad++; $display("FAIL flush_a_kept got=%h exp=12345678", mdu_a); end
    step();
    idle_in();
    step();
  endtask

  task automatic test_proto();
    @(negedge clk);
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL perr_clean got=%b exp=0", proto_err); end
`ifdef MDU_ISSUE_CHECK_EN
    step();
    busy_force = 1'b1;
    step();
    busy_force = 1'b0;
    @(negedge clk);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_set got=%b exp=1", proto_err); end
    repeat (3) step();
    @(negedge clk);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_sticky got=%b exp=1", proto_err); end
    reset = 1'b0;
    #1;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL perr_reset got=%b exp=0", proto_err); end
    step();
    reset = 1'b1;
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_zero();
    test_back_to_back();
    test_mthi_mfhi();
    test_kill();
    test_flush();
    test_proto();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_issue.md
Name: mdu_issue

Overview:
- Pipeline-side initiator for the E-stage multiply/divide unit.
- Accepts decoded MDU instructions (mult/multu/div/divu/mthi/mtlo/mfhi/mflo) from the E stage and registers the request for one cycle.
- Drives Op/A/B to the MDU and tracks the MDU's busy window with a shadow counter.
- Produces the pipeline stall and returns hi/lo read data; cancels a registered request when the pipeline flushes it for an exception or interrupt.

Parameters:
- MUL_LAT, 5, cycles the MDU stays busy after sampling mult/multu.
- DIV_LAT, 10, cycles the MDU stays busy after sampling div/divu with nonzero divisor.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- e_valid  in  1  E stage holds a live instruction.
- e_op  in  4  decoded MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 7 mthi, 8 mtlo.
- e_rd_hi  in  1  E instruction is mfhi.
- e_rd_lo  in  1  E instruction is mflo.
- e_a  in  32  rs operand (forwarded).
- e_b  in  32  rt operand (forwarded).
- e_flush  in  1  kill the current E instruction this cycle.
- req_kill  in  1  kill the registered request (its instruction was flushed in M).
- stall  out  1  freeze F/D/E, bubble into M.
- rd_data  out  32  hi when e_rd_hi, lo when e_rd_lo, else 0.
- mdu_op  out  4  Op to MDU.
- mdu_a  out  32  A to MDU.
- mdu_b  out  32  B to MDU.
- mdu_busy  in  1  MDU Busy.
- mdu_hi  in  32  MDU hi.
- mdu_lo  in  32  MDU lo.
- proto_err  out  1  sticky protocol mismatch (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, req_op=0, req_a=req_b=0, shadow cnt=0, proto_err=0. Outputs: mdu_op=0, stall=0.
- e_use = e_valid & (e_op!=0 | e_rd_hi | e_rd_lo).
- hazard = (state!=IDLE) | mdu_busy.
- stall = e_use & hazard. stall is combinational and must not depend on e_flush.
- Accept: on an edge where e_valid & e_op!=0 & !hazard & !e_flush:
  - capture req_op=e_op, req_a=e_a, req_b=e_b;
  - go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mdu_op = req_kill ? 0 : req_op; mdu_a/mdu_b = req_a/req_b.
  - At the edge, load cnt:
    - MUL_LAT for ops 1/2;
    - DIV_LAT for ops 3/4 with req_b!=0;
    - 0 for div with req_b==0, ops 7/8, or killed requests.
  - Next state: WAIT if cnt loaded nonzero, else IDLE. Clear req_op.
- WAIT: cnt decrements each edge; go to IDLE when cnt transitions 1->0.
- IDLE/WAIT: mdu_op=0; mdu_a/mdu_b hold the last registered values.
- Accept-to-MDU-sample latency: 1 cycle. An MDU op following an MDU op issues once cnt==0 and mdu_busy==0.
- mfhi/mflo never enter ISSUE. They stall while hazard is set, then read mdu_hi/mdu_lo combinationally.
- mthi followed immediately by mfhi: mfhi stalls 1 cycle (ISSUE), then reads the new hi.
- A request accepted while e_flush=1 is dropped; the state is unchanged.
- reset deasserting mid-WAIT: not applicable. Reset clears everything; the MDU is reset by the same net.

Optional Feature:
- Macro MDU_ISSUE_CHECK_EN.
- When defined: each edge in WAIT or IDLE (not ISSUE) compares mdu_busy against (cnt!=0). Any mismatch sets proto_err, which stays set until reset.
- When undefined: proto_err is tied to 0, and the comparison logic is absent.
- stall always uses mdu_busy OR state, in both builds.

Decomposition:
- Shared package mdu_pkg:
  - op constants MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=7, MDU_MTLO=8;
  - state encoding IDLE/ISSUE/WAIT;
  - MUL_LAT/DIV_LAT defaults.
- The MDU itself consumes the op constants.
- One natural sub-module: mdu_lat_cnt (load value, decrement, zero flag).

Test Plan:
- mult e_a=-3, e_b=7 accepted: next cycle mdu_op=1, mdu_a=0xFFFFFFFD, stall=1. Then 5 WAIT cycles. A following mflo stalls until IDLE and reads 0xFFFFFFEB.
- div e_a=7, e_b=0: ISSUE 1 cycle, then IDLE with cnt=0 and no WAIT. A following mfhi stalls exactly 1 cycle.
- divu 100/7 followed by a back-to-back mult: mult stalls 1+10 cycles, then issues. Final hi/lo match 100*mult operands.
- mtlo 0x12345678 with req_kill=1 in ISSUE: mdu_op=0, a following mflo returns the old lo, and no WAIT is entered.
- mult in E with e_flush=1: no ISSUE; state stays IDLE, stall=0.
- With MDU_ISSUE_CHECK_EN, force mdu_busy=1 for one cycle during IDLE: proto_err=1 and stays 1 until reset=0.
